// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: bundle of every non-clock/reset signal of the ALU operand stage.
//   master : upstream/environment side (drives decode fields, bypass buses, flush, out_ready)
//   slave  : the operand stage itself (drives in_ready, registered ALU operands, stall_count)
// Groups: decode input handshake (in_*), EX/MEM bypass buses (ex_*, mem_*), flush,
//         ALU-side output handshake (out_valid/out_ready, opsel, A, B, out_*), stall_count.
interface alu_operand_stage_if #(
    parameter int unsigned REG_IDX_W = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [5:0]           in_opsel;
    logic [REG_IDX_W-1:0] in_rs1_idx;
    logic [REG_IDX_W-1:0] in_rs2_idx;
    logic [DATA_W-1:0]    in_rs1_val;
    logic [DATA_W-1:0]    in_rs2_val;
    logic [15:0]          in_imm;
    logic                 in_use_imm;
    logic [REG_IDX_W-1:0] in_rd_idx;
    logic                 in_wr_en;
    logic                 in_is_load;

    logic                 ex_wr_en;
    logic                 ex_is_load;
    logic [REG_IDX_W-1:0] ex_rd_idx;
    logic [DATA_W-1:0]    ex_value;
    logic                 mem_wr_en;
    logic [REG_IDX_W-1:0] mem_rd_idx;
    logic [DATA_W-1:0]    mem_value;

    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           opsel;
    logic [DATA_W-1:0]    A;
    logic [DATA_W-1:0]    B;
    logic [REG_IDX_W-1:0] out_rd_idx;
    logic                 out_wr_en;
    logic                 out_is_load;
    logic [CNT_W-1:0]     stall_count;

    modport master (
        output in_valid, in_opsel, in_rs1_idx, in_rs2_idx, in_rs1_val, in_rs2_val,
               in_imm, in_use_imm, in_rd_idx, in_wr_en, in_is_load,
               ex_wr_en, ex_is_load, ex_rd_idx, ex_value,
               mem_wr_en, mem_rd_idx, mem_value, flush, out_ready,
        input  in_ready, out_valid, opsel, A, B, out_rd_idx, out_wr_en, out_is_load,
               stall_count
    );

    modport slave (
        input  in_valid, in_opsel, in_rs1_idx, in_rs2_idx, in_rs1_val, in_rs2_val,
               in_imm, in_use_imm, in_rd_idx, in_wr_en, in_is_load,
               ex_wr_en, ex_is_load, ex_rd_idx, ex_value,
               mem_wr_en, mem_rd_idx, mem_value, flush, out_ready,
        output in_ready, out_valid, opsel, A, B, out_rd_idx, out_wr_en, out_is_load,
               stall_count
    );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: pipeline register directly ahead of the ALU. Resolves operands A/B
// (register or sign-extended immediate), forwards from EX/MEM, detects hazards and stalls,
// and presents registered opsel/A/B one cycle after acceptance (valid/ready, bubble, flush).
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - alu_operand_stage_if.slave (decode input, bypass buses, flush, ALU output,
//           stall_count)
// Build option: define ALU_OPERAND_FWD_EN to enable EX/MEM forwarding. When undefined, any
// used source matching a pending EX or MEM write stalls until the match clears and operands
// always come from the register-file values.
module alu_operand_stage #(
    parameter int unsigned REG_IDX_W = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 16
) (
    input logic               clk,
    input logic               reset,
    alu_operand_stage_if.slave bus
);
    localparam logic [5:0] OpMvhi = 6'd11;

    logic                 is_mvhi;
    logic                 is_ft;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 ex_m1;
    logic                 ex_m2;
    logic                 mem_m1;
    logic                 mem_m2;
    logic [DATA_W-1:0]    rs1_op;
    logic [DATA_W-1:0]    rs2_op;
    logic [DATA_W-1:0]    imm_ext;
    logic [DATA_W-1:0]    a_d;
    logic [DATA_W-1:0]    b_d;
    logic                 hazard;
    logic                 in_ready;
    logic                 accept;

    logic                 out_valid_q;
    logic [5:0]           opsel_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [REG_IDX_W-1:0] rd_idx_q;
    logic                 wr_en_q;
    logic                 is_load_q;
    logic [CNT_W-1:0]     stall_q;

    // MVHI and the F/T class ignore rs1; MVHI also ignores rs2.
    assign is_mvhi = (bus.in_opsel == OpMvhi);
    assign is_ft   = bus.in_opsel[4] && (bus.in_opsel[2:0] == 3'b000);
    assign use_rs1 = ~(is_mvhi | is_ft);
    assign use_rs2 = ~bus.in_use_imm & ~is_mvhi;

    // Raw destination matches; load-ness is qualified separately below.
    assign ex_m1  = bus.ex_wr_en  && (bus.ex_rd_idx  == bus.in_rs1_idx);
    assign ex_m2  = bus.ex_wr_en  && (bus.ex_rd_idx  == bus.in_rs2_idx);
    assign mem_m1 = bus.mem_wr_en && (bus.mem_rd_idx == bus.in_rs1_idx);
    assign mem_m2 = bus.mem_wr_en && (bus.mem_rd_idx == bus.in_rs2_idx);

`ifdef ALU_OPERAND_FWD_EN
    // A load in EX has no data yet, so it never forwards; EX beats MEM as the younger write.
    assign rs1_op = (ex_m1 && !bus.ex_is_load) ? bus.ex_value :
                    mem_m1                     ? bus.mem_value : bus.in_rs1_val;
    assign rs2_op = (ex_m2 && !bus.ex_is_load) ? bus.ex_value :
                    mem_m2                     ? bus.mem_value : bus.in_rs2_val;
    assign hazard = bus.in_valid && bus.ex_is_load &&
                    ((use_rs1 && ex_m1) || (use_rs2 && ex_m2));
`else
    // Without bypass paths, wait until neither in-flight write targets a used source.
    assign rs1_op = bus.in_rs1_val;
    assign rs2_op = bus.in_rs2_val;
    assign hazard = bus.in_valid &&
                    ((use_rs1 && (ex_m1 || mem_m1)) || (use_rs2 && (ex_m2 || mem_m2)));
`endif

    assign imm_ext = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};
    assign a_d     = use_rs1 ? rs1_op : '0;
    assign b_d     = bus.in_use_imm ? imm_ext : (use_rs2 ? rs2_op : '0);

    assign in_ready = ~hazard & (~out_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            opsel_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_idx_q    <= '0;
            wr_en_q     <= 1'b0;
            is_load_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            // Flush wins over a simultaneous accept; the incoming instruction is dropped.
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                opsel_q     <= bus.in_opsel;
                a_q         <= a_d;
                b_q         <= b_d;
                rd_idx_q    <= bus.in_rd_idx;
                wr_en_q     <= bus.in_wr_en;
                is_load_q   <= bus.in_is_load;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (hazard && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.opsel       = opsel_q;
    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.out_rd_idx  = rd_idx_q;
    assign bus.out_wr_en   = wr_en_q;
    assign bus.out_is_load = is_load_q;
    assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: the driver pushes the hand-computed result of each
// instruction when the stage accepts it; a monitor pops and compares on every output transfer.
// Expected values follow the ALU_OPERAND_FWD_EN setting of the build.
module tb_alu_operand_stage;
    localparam int unsigned RW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [5:0]    opsel;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] rd;
        logic          wr;
        logic          ld;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    alu_operand_stage_if #(.REG_IDX_W(RW), .DATA_W(DW), .CNT_W(CW)) bus ();

    alu_operand_stage #(.REG_IDX_W(RW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   exp_stall = 0;
    exp_t pend;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in_valid   = 1'b0;
        bus.in_opsel   = '0;
        bus.in_rs1_idx = '0;
        bus.in_rs2_idx = '0;
        bus.in_rs1_val = '0;
        bus.in_rs2_val = '0;
        bus.in_imm     = '0;
        bus.in_use_imm = 1'b0;
        bus.in_rd_idx  = '0;
        bus.in_wr_en   = 1'b0;
        bus.in_is_load = 1'b0;
    endtask

    task automatic set_ex(input logic wr, input logic ld, input logic [RW-1:0] rd,
                          input logic [DW-1:0] v);
        bus.ex_wr_en   = wr;
        bus.ex_is_load = ld;
        bus.ex_rd_idx  = rd;
        bus.ex_value   = v;
    endtask

    task automatic set_mem(input logic wr, input logic [RW-1:0] rd, input logic [DW-1:0] v);
        bus.mem_wr_en  = wr;
        bus.mem_rd_idx = rd;
        bus.mem_value  = v;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [RW-1:0] r1,
                             input logic [DW-1:0] v1, input logic [RW-1:0] r2,
                             input logic [DW-1:0] v2, input logic [15:0] imm, input logic ui,
                             input logic [RW-1:0] rd, input logic wr, input logic ld);
        bus.in_valid   = 1'b1;
        bus.in_opsel   = op;
        bus.in_rs1_idx = r1;
        bus.in_rs1_val = v1;
        bus.in_rs2_idx = r2;
        bus.in_rs2_val = v2;
        bus.in_imm     = imm;
        bus.in_use_imm = ui;
        bus.in_rd_idx  = rd;
        bus.in_wr_en   = wr;
        bus.in_is_load = ld;
    endtask

    task automatic expect_out(input logic [5:0] op, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [RW-1:0] rd,
                              input logic wr, input logic ld);
        pend = '{opsel: op, a: a, b: b, rd: rd, wr: wr, ld: ld};
    endtask

    task automatic ready_is(input string name, input logic exp);
        @(negedge clk);
        chk(name, bus.in_ready, exp);
    endtask

    // Monitor: compare on transfer, then record what the stage takes in this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got opsel %0h A %0h with empty scoreboard",
                             bus.opsel, bus.A);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    chk("out_opsel", bus.opsel, e.opsel);
                    chk("out_A", bus.A, e.a);
                    chk("out_B", bus.B, e.b);
                    chk("out_rd_idx", bus.out_rd_idx, e.rd);
                    chk("out_wr_en", bus.out_wr_en, e.wr);
                    chk("out_is_load", bus.out_is_load, e.ld);
                end
            end
            if (bus.flush) sb.delete();
            else if (bus.in_valid && bus.in_ready) sb.push_back(pend);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        set_ex(0, 0, 0, 0);
        set_mem(0, 0, 0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        pend          = '0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_A", bus.A, 0);
        chk("rst_B", bus.B, 0);
        chk("rst_stall", bus.stall_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ADD r3=r1+r2, then a back-to-back load-flagged op
        set_instr(6'd0, 4'd1, 32'd5, 4'd2, 32'd7, 16'h0, 0, 4'd3, 1, 0);
        expect_out(6'd0, 32'd5, 32'd7, 4'd3, 1, 0);
        ready_is("add_ready", 1);
        tick();
        set_instr(6'd3, 4'd6, 32'h100, 4'd7, 32'h1, 16'h0, 0, 4'd8, 1, 1);
        expect_out(6'd3, 32'h100, 32'h1, 4'd8, 1, 1);
        ready_is("b2b_ready", 1);
        tick();
        clear_in();

        // Immediate with EX and MEM both writing r1
        set_instr(6'd1, 4'd1, 32'd3, 4'd5, 32'd0, 16'hFFFC, 1, 4'd2, 1, 0);
        set_ex(1, 0, 4'd1, 32'd100);
        set_mem(1, 4'd1, 32'd50);
`ifdef ALU_OPERAND_FWD_EN
        expect_out(6'd1, 32'd100, 32'hFFFF_FFFC, 4'd2, 1, 0);
        ready_is("imm_fwd_ready", 1);
`else
        expect_out(6'd1, 32'd3, 32'hFFFF_FFFC, 4'd2, 1, 0);
        ready_is("imm_stall_ex", 0);
        tick();
        set_ex(0, 0, 0, 0);
        ready_is("imm_stall_mem", 0);
        tick();
        set_mem(0, 0, 0);
        ready_is("imm_ready", 1);
        exp_stall += 2;
`endif
        tick();
        clear_in();
        set_ex(0, 0, 0, 0);
        set_mem(0, 0, 0);
        @(negedge clk);
        chk("stall_after_imm", bus.stall_count, exp_stall);
        tick();

        // Load r4 in EX, consumer reads r4
        set_instr(6'd0, 4'd4, 32'd1, 4'd2, 32'd7, 16'h0, 0, 4'd5, 1, 0);
        set_ex(1, 1, 4'd4, 32'd0);
        expect_out(6'd0, 32'd9, 32'd7, 4'd5, 1, 0);
        ready_is("lu_stall", 0);
        tick();
        set_ex(0, 0, 0, 0);
        set_mem(1, 4'd4, 32'd9);
        exp_stall += 1;
        @(negedge clk);
        chk("lu_bubble", bus.out_valid, 0);
        chk("lu_stall_cnt", bus.stall_count, exp_stall);
`ifdef ALU_OPERAND_FWD_EN
        chk("lu_ready", bus.in_ready, 1);
`else
        chk("lu_stall_mem", bus.in_ready, 0);
        tick();
        set_mem(0, 0, 0);
        bus.in_rs1_val = 32'd9;
        exp_stall += 1;
        ready_is("lu_ready", 1);
`endif
        tick();
        clear_in();
        set_mem(0, 0, 0);
        @(negedge clk);
        chk("stall_after_lu", bus.stall_count, exp_stall);
        tick();

        // MVHI and F/T ignore their unused sources even with matching EX/MEM writes
        set_ex(1, 1, 4'd9, 32'd0);
        set_mem(1, 4'd9, 32'h33);
        set_instr(6'd11, 4'd9, 32'hDEAD, 4'd9, 32'hBEEF, 16'h1234, 1, 4'd10, 1, 0);
        expect_out(6'd11, 32'd0, 32'h1234, 4'd10, 1, 0);
        ready_is("mvhi_ready", 1);
        tick();
        set_instr(6'd16, 4'd9, 32'hAA, 4'd3, 32'h77, 16'h0, 0, 4'd11, 0, 0);
        expect_out(6'd16, 32'd0, 32'h77, 4'd11, 0, 0);
        ready_is("ft_ready", 1);
        tick();
        clear_in();
        set_ex(0, 0, 0, 0);
        set_mem(0, 0, 0);

        // ALU result for r2 in EX, consumer reads r2 as rs2
        set_instr(6'd0, 4'd1, 32'd1, 4'd2, 32'h10, 16'h0, 0, 4'd12, 1, 0);
        set_ex(1, 0, 4'd2, 32'h55);
        expect_out(6'd0, 32'd1, 32'h55, 4'd12, 1, 0);
`ifdef ALU_OPERAND_FWD_EN
        ready_is("alu_fwd_ready", 1);
`else
        ready_is("alu_stall_ex", 0);
        tick();
        set_ex(0, 0, 0, 0);
        set_mem(1, 4'd2, 32'h55);
        ready_is("alu_stall_mem", 0);
        tick();
        set_mem(0, 0, 0);
        bus.in_rs2_val = 32'h55;
        ready_is("alu_ready", 1);
        exp_stall += 2;
`endif
        tick();
        clear_in();
        set_ex(0, 0, 0, 0);
        set_mem(0, 0, 0);

        // Backpressure: hold for 3 cycles, then flush the held and incoming instruction
        set_instr(6'd2, 4'd5, 32'h11, 4'd6, 32'h22, 16'h0, 0, 4'd7, 1, 0);
        expect_out(6'd2, 32'h11, 32'h22, 4'd7, 1, 0);
        ready_is("bp_accept", 1);
        tick();
        bus.out_ready = 1'b0;
        set_instr(6'd4, 4'd1, 32'h1, 4'd2, 32'h2, 16'h0, 0, 4'd1, 1, 0);
        expect_out(6'd4, 32'h1, 32'h2, 4'd1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_ready", bus.in_ready, 0);
            chk("bp_A", bus.A, 32'h11);
            chk("bp_B", bus.B, 32'h22);
            tick();
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        clear_in();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_held", bus.out_valid, 0);
        tick();
        set_instr(6'd5, 4'd1, 32'h3, 4'd2, 32'h4, 16'h0, 0, 4'd6, 1, 0);
        expect_out(6'd5, 32'h3, 32'h4, 4'd6, 1, 0);
        bus.flush = 1'b1;
        ready_is("flush_in_ready", 1);
        tick();
        bus.flush = 1'b0;
        clear_in();
        @(negedge clk);
        chk("flush_accept", bus.out_valid, 0);
        tick();

        // Stall counter saturation (4-bit counter)
        set_instr(6'd0, 4'd4, 32'h44, 4'd1, 32'h1, 16'h0, 0, 4'd13, 1, 0);
        set_ex(1, 1, 4'd4, 32'd0);
        expect_out(6'd0, 32'h44, 32'h1, 4'd13, 1, 0);
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        chk("stall_sat", bus.stall_count, 15);
        tick();
        set_ex(0, 0, 0, 0);
        ready_is("sat_ready", 1);
        tick();
        clear_in();

        // Reset mid-stream while an output is held
        set_instr(6'd6, 4'd1, 32'h5, 4'd2, 32'h6, 16'h0, 0, 4'd14, 1, 1);
        expect_out(6'd6, 32'h5, 32'h6, 4'd14, 1, 1);
        tick();
        clear_in();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("mid_valid", bus.out_valid, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_opsel", bus.opsel, 0);
        chk("mid_rst_A", bus.A, 0);
        chk("mid_rst_B", bus.B, 0);
        chk("mid_rst_rd", bus.out_rd_idx, 0);
        chk("mid_rst_wr", bus.out_wr_en, 0);
        chk("mid_rst_ld", bus.out_is_load, 0);
        chk("mid_rst_stall", bus.stall_count, 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", bus.in_ready, 1);

        repeat (3) tick();
        chk("outputs_seen", n_out, 8);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Pipeline register stage directly upstream of the ALU: accepts decoded instruction fields and register-file read values, resolves operands A and B (register or sign-extended immediate), applies data forwarding from the two downstream stages, and detects load-use hazards. It presents registered `opsel`, `A` and `B` to the ALU one cycle after acceptance, using a valid/ready handshake with bubble insertion and flush.

## Interface
- `REG_IDX_W`, default 4: register index width (16 architectural registers).
- `DATA_W`, default 32: operand width.
- `CNT_W`, default 16: stall counter width.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage accepts this cycle.
- `in_opsel`  in  6  ALU operation select.
- `in_rs1_idx`, `in_rs2_idx`  in  REG_IDX_W  source register indices.
- `in_rs1_val`, `in_rs2_val`  in  DATA_W  register-file read data.
- `in_imm`  in  16  immediate field.
- `in_use_imm`  in  1  B comes from the immediate, not rs2.
- `in_rd_idx`  in  REG_IDX_W  destination index.
- `in_wr_en`  in  1  instruction writes rd.
- `in_is_load`  in  1  instruction is a load.
- `ex_wr_en`, `ex_is_load`  in  1  ALU-output stage writes rd / is a load.
- `ex_rd_idx`  in  REG_IDX_W; `ex_value`  in  DATA_W  ALU-output stage result.
- `mem_wr_en`  in  1; `mem_rd_idx`  in  REG_IDX_W; `mem_value`  in  DATA_W  memory stage result (load data valid).
- `flush`  in  1  discard held and incoming instruction.
- `out_valid`  out  1; `out_ready`  in  1  downstream handshake.
- `opsel`  out  6; `A`, `B`  out  DATA_W  ALU operands (registered).
- `out_rd_idx`  out  REG_IDX_W; `out_wr_en`, `out_is_load`  out  1  passed through.
- `stall_count`  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Operand use: rs1 is used unless `in_opsel`==11 (MVHI) or (`in_opsel[4]` and `in_opsel[2:0]`==0, i.e. F/T). rs2 is used iff `in_use_imm`==0 and rs1 rule does not exclude it for MVHI.
- B = `in_use_imm` ? sign-extend(`in_imm`) to DATA_W : rs2 operand. A = rs1 operand (0 when unused).
- Forwarding per used source: match `ex_wr_en` & `ex_rd_idx`==idx and not `ex_is_load` -> `ex_value`; otherwise match `mem_wr_en` & `mem_rd_idx`==idx -> `mem_value`; otherwise register-file value. EX has priority over MEM.
- Load-use hazard: `in_valid` & `ex_wr_en` & `ex_is_load` & `ex_rd_idx` matches a used source -> `hazard`=1.
- `in_ready` = ~`hazard` & (~`out_valid` | `out_ready`).
- Output register: on `flush` -> `out_valid`<=0. Else if `in_valid`&`in_ready` -> load resolved fields, `out_valid`<=1. Else if `out_ready` -> `out_valid`<=0 (bubble). Else hold all outputs unchanged.
- `stall_count` increments each cycle `hazard`=1 and saturates at all-ones.

## Timing
- Reset: `out_valid`, `opsel`, `A`, `B`, `out_rd_idx`, `out_wr_en`, `out_is_load`, `stall_count` all 0 immediately (asynchronous).
- Latency: 1 cycle from accepted input to `out_valid`/operands.
- Throughput: 1 per cycle absent hazard and backpressure.
- Load-use: exactly one bubble when the load advances out of EX the next cycle; the operand is then forwarded from MEM.
- `flush` overrides a simultaneous accept; `in_ready` is still computed normally and the instruction is dropped.
- Operands are stable while `out_valid`&~`out_ready`.
- `in_ready` is combinational from inputs; no combinational path from `out_valid` outputs back into forwarding.

## Configuration
- `ALU_OPERAND_FWD_EN` defined: forwarding as above.
- Undefined: no forwarding; any used source matching `ex_wr_en`/`ex_rd_idx` or `mem_wr_en`/`mem_rd_idx` raises `hazard` (stall until clear); operands always come from register-file values.

## Test plan
- Reset mid-stream with `out_valid`=1 -> all outputs 0 the same cycle; `in_ready`=1 after release.
- ADD r3=r1+r2, rs1_val=5, rs2_val=7, no matches -> next cycle `opsel`=0, A=5, B=7, `out_valid`=1.
- `in_use_imm`=1, imm=16'hFFFC, ex writes r1 with `ex_value`=100, mem writes r1 with 50 -> A=100, B=32'hFFFFFFFC.
- Load r4 in EX, next instruction reads r4 -> `in_ready`=0 one cycle, bubble, `stall_count`=1; after load moves to MEM with `mem_value`=9, A=9.
- `out_ready`=0 for 3 cycles -> outputs held, `in_ready`=0; `flush` asserted with `in_valid`=1 -> `out_valid`=0 next cycle.
- Without `ALU_OPERAND_FWD_EN`: ALU write to r2 in EX, consumer reads r2 -> stall until both EX and MEM no longer match, then register-file value used.
